// File: rtl/multi_timer.sv
// Bank of N_CH independent down-counting timers sharing one tick strobe.
// Each channel supports one-shot or periodic operation with a sticky timeout flag.
module multi_timer #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_en,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH*WIDTH-1:0] load_val,
  input  logic [N_CH-1:0]       clear,
  output logic [N_CH-1:0]       running,
  output logic [N_CH-1:0]       expire,
  output logic [N_CH-1:0]       timeout,
  output logic [N_CH*WIDTH-1:0] count_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_q, state_d;
      logic [WIDTH-1:0] count_q, count_d;
      logic [WIDTH-1:0] reload_q, reload_d;
      logic             mode_q, mode_d;
      logic             running_q, running_d;
      logic             expire_q, expire_d;
      logic             timeout_q, timeout_d;
      logic             fire;
      logic [WIDTH-1:0] ld;

      assign ld = load_val[gi*WIDTH +: WIDTH];

      always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        fire     = 1'b0;

        if (stop[gi]) begin
          state_d = S_IDLE;
        end else if (start[gi]) begin
          // A zero load expires immediately so periodic mode can never spin on a zero period.
          if (ld != '0) begin
            count_d  = ld;
            reload_d = ld;
            mode_d   = mode[gi];
            state_d  = S_RUN;
          end else begin
            count_d = '0;
            state_d = S_EXPIRED;
            fire    = 1'b1;
          end
        end else if (state_q == S_RUN && tick_en) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (mode_q) begin
            count_d = reload_q;
            fire    = 1'b1;
          end else begin
            count_d = '0;
            state_d = S_EXPIRED;
            fire    = 1'b1;
          end
        end

        running_d = (state_d == S_RUN);
        expire_d  = fire;
        // Expiry beats a same-cycle clear.
        timeout_d = fire | (timeout_q & ~clear[gi]);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q   <= S_IDLE;
          count_q   <= '0;
          reload_q  <= '0;
          mode_q    <= 1'b0;
          running_q <= 1'b0;
          expire_q  <= 1'b0;
          timeout_q <= 1'b0;
        end else begin
          state_q   <= state_d;
          count_q   <= count_d;
          reload_q  <= reload_d;
          mode_q    <= mode_d;
          running_q <= running_d;
          expire_q  <= expire_d;
          timeout_q <= timeout_d;
        end
      end

      assign running[gi]                = running_q;
      assign expire[gi]                 = expire_q;
      assign timeout[gi]                = timeout_q;
      assign count_o[gi*WIDTH +: WIDTH] = count_q;
    end
  endgenerate

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: stimulus queues expected per-channel snapshots
// tagged with the cycle they must appear in; a monitor compares them on the falling edge.
module tb_multi_timer;
  localparam int N_CH  = 4;
  localparam int WIDTH = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  tick_en;
  logic [N_CH-1:0]       start, stop, mode, clear;
  logic [N_CH*WIDTH-1:0] load_val;
  logic [N_CH-1:0]       running, expire, timeout;
  logic [N_CH*WIDTH-1:0] count_o;

  multi_timer #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .start(start), .stop(stop),
    .mode(mode), .load_val(load_val), .clear(clear), .running(running),
    .expire(expire), .timeout(timeout), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    int               ch;
    logic             run;
    logic             to;
    logic [WIDTH-1:0] cnt;
    logic             ex;
  } snap_t;

  snap_t sb[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_pulses [N_CH];
  int    seen_pulses[N_CH];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every snapshot due this cycle, and count expire pulses.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        automatic snap_t e = sb[i];
        automatic logic [WIDTH-1:0] act_cnt = count_o[e.ch*WIDTH +: WIDTH];
        n_cmp++;
        if (running[e.ch] !== e.run || timeout[e.ch] !== e.to ||
            act_cnt !== e.cnt || expire[e.ch] !== e.ex) begin
          n_bad++;
          $display("FAIL snap cyc=%0d ch=%0d: got run=%b to=%b cnt=%0d ex=%b, want run=%b to=%b cnt=%0d ex=%b",
                   cyc, e.ch, running[e.ch], timeout[e.ch], act_cnt, expire[e.ch],
                   e.run, e.to, e.cnt, e.ex);
        end else begin
          $display("ok   snap cyc=%0d ch=%0d run=%b to=%b cnt=%0d ex=%b",
                   cyc, e.ch, e.run, e.to, e.cnt, e.ex);
        end
        sb.delete(i);
      end
    end
    for (int c = 0; c < N_CH; c++)
      if (expire[c] === 1'b1) seen_pulses[c]++;
  end

  // Expect a snapshot of channel ch after the coming rising edge.
  task automatic expect_ch(input int ch, input logic run, input logic to,
                           input int cnt, input logic ex);
    snap_t e;
    e.cyc = cyc + 1; e.ch = ch; e.run = run; e.to = to; e.cnt = WIDTH'(cnt); e.ex = ex;
    sb.push_back(e);
    if (ex) exp_pulses[ch]++;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_load(input int ch, input int val);
    load_val[ch*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  int m_cnt;
  logic m_ex;

  initial begin
    for (int c = 0; c < N_CH; c++) begin exp_pulses[c] = 0; seen_pulses[c] = 0; end
    reset = 1'b1; tick_en = 1'b0; start = '0; stop = '0; mode = '0; clear = '0; load_val = '0;
    nxt();

    // Reset state
    for (int c = 0; c < N_CH; c++) expect_ch(c, 0, 0, 0, 0);
    nxt();
    reset = 1'b0;

    // ch0 one-shot, load 3, tick every cycle
    start = 4'b0001; mode = 4'b0000; set_load(0, 3); tick_en = 1'b1;
    expect_ch(0, 1, 0, 3, 0); nxt();
    start = '0;
    expect_ch(0, 1, 0, 2, 0); nxt();
    expect_ch(0, 1, 0, 1, 0); nxt();
    expect_ch(0, 0, 1, 0, 1); nxt();
    expect_ch(0, 0, 1, 0, 0); nxt();
    expect_ch(0, 0, 1, 0, 0); nxt();

    // ch1 periodic, load 2, tick every second cycle; load/mode changes mid-run ignored
    tick_en = 1'b0; start = 4'b0010; mode = 4'b0010; set_load(1, 2);
    expect_ch(1, 1, 0, 2, 0); nxt();
    start = '0;
    m_cnt = 2;
    for (int k = 1; k <= 12; k++) begin
      tick_en = (k % 2 == 1);
      if (k == 2) begin set_load(1, 9); mode = 4'b0000; end
      m_ex = 1'b0;
      if (tick_en) begin
        if (m_cnt == 1) begin m_cnt = 2; m_ex = 1'b1; end
        else m_cnt = m_cnt - 1;
      end
      expect_ch(1, 1, (k >= 3), m_cnt, m_ex);
      nxt();
    end
    tick_en = 1'b0; stop = 4'b0010;
    expect_ch(1, 0, 1, m_cnt, 0); nxt();
    stop = '0;

    // ch2: run to count 5, then stop+start together, then zero-load start
    start = 4'b0100; mode = 4'b0000; set_load(2, 7);
    expect_ch(2, 1, 0, 7, 0); nxt();
    start = '0; tick_en = 1'b1;
    expect_ch(2, 1, 0, 6, 0); nxt();
    expect_ch(2, 1, 0, 5, 0); nxt();
    stop = 4'b0100; start = 4'b0100; set_load(2, 11);
    expect_ch(2, 0, 0, 5, 0); nxt();
    stop = '0; set_load(2, 0);
    expect_ch(2, 0, 1, 0, 1); nxt();
    start = '0;
    expect_ch(2, 0, 1, 0, 0); nxt();

    // ch3 periodic load 3: expiry with clear in same cycle, then clear alone
    tick_en = 1'b0; start = 4'b1000; mode = 4'b1000; set_load(3, 3);
    expect_ch(3, 1, 0, 3, 0); nxt();
    start = '0; tick_en = 1'b1;
    expect_ch(3, 1, 0, 2, 0); nxt();
    expect_ch(3, 1, 0, 1, 0); nxt();
    clear = 4'b1000;
    expect_ch(3, 1, 1, 3, 1); nxt();
    tick_en = 1'b0;
    expect_ch(3, 1, 0, 3, 0); nxt();
    clear = '0;
    // Restart at count 1 with a tick: no expire for the abandoned period
    tick_en = 1'b1;
    expect_ch(3, 1, 0, 2, 0); nxt();
    expect_ch(3, 1, 0, 1, 0); nxt();
    start = 4'b1000; set_load(3, 5);
    expect_ch(3, 1, 0, 5, 0); nxt();
    start = '0; tick_en = 1'b0;

    // All channels started, reset mid-count
    start = 4'b1111; mode = 4'b0000;
    set_load(0, 10); set_load(1, 20); set_load(2, 30); set_load(3, 40);
    expect_ch(0, 1, 1, 10, 0); expect_ch(1, 1, 1, 20, 0);
    expect_ch(2, 1, 1, 30, 0); expect_ch(3, 1, 0, 40, 0);
    nxt();
    start = '0; tick_en = 1'b1;
    nxt(); nxt();
    expect_ch(0, 1, 1, 7, 0); expect_ch(1, 1, 1, 17, 0);
    expect_ch(2, 1, 1, 27, 0); expect_ch(3, 1, 0, 37, 0);
    nxt();
    reset = 1'b1;
    for (int c = 0; c < N_CH; c++) expect_ch(c, 0, 0, 0, 0);
    nxt();
    reset = 1'b0;
    nxt(); nxt();
    for (int c = 0; c < N_CH; c++) expect_ch(c, 0, 0, 0, 0);
    nxt();

    // Restart ch0 after reset
    start = 4'b0001; set_load(0, 2);
    expect_ch(0, 1, 0, 2, 0); nxt();
    start = '0;
    expect_ch(0, 1, 0, 1, 0); nxt();
    expect_ch(0, 0, 1, 0, 1); nxt();
    expect_ch(0, 0, 1, 0, 0); nxt();
    nxt();

    for (int c = 0; c < N_CH; c++) begin
      n_cmp++;
      if (seen_pulses[c] != exp_pulses[c]) begin
        n_bad++;
        $display("FAIL pulses ch=%0d: got %0d expire pulses, want %0d", c, seen_pulses[c], exp_pulses[c]);
      end else begin
        $display("ok   pulses ch=%0d count=%0d", c, seen_pulses[c]);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d unchecked snapshots, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter N_CH, default 4: number of independent timer channels (1..16).
REQ-002 Parameter WIDTH, default 16: counter width per channel in bits (2..32).
REQ-003 clk  input  1: system clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 tick_en  input  1: shared count-enable strobe (prescaler output); counters decrement only in cycles where it is high.
REQ-006 start  input  N_CH: per-channel start/restart request, sampled each cycle.
REQ-007 stop  input  N_CH: per-channel stop request, sampled each cycle.
REQ-008 mode  input  N_CH: per-channel mode, sampled with start; 0 = one-shot, 1 = periodic.
REQ-009 load_val  input  N_CH*WIDTH: per-channel reload value; channel i uses bits [i*WIDTH +: WIDTH].
REQ-010 clear  input  N_CH: per-channel clear of the sticky timeout flag.
REQ-011 running  output  N_CH: channel is in RUN.
REQ-012 expire  output  N_CH: one-cycle pulse on each channel expiry.
REQ-013 timeout  output  N_CH: sticky expiry flag per channel.
REQ-014 count_o  output  N_CH*WIDTH: current counter value per channel, same packing as load_val.

Function
REQ-015 Each channel SHALL run an independent FSM with states IDLE, RUN and EXPIRED, plus WIDTH-bit count, WIDTH-bit reload and 1-bit mode registers.
REQ-016 Per-channel priority SHALL be stop > start > tick-driven decrement/expiry.
REQ-017 stop=1 in any state: next state IDLE; count holds its value; reload, mode and timeout are unchanged.
REQ-018 start=1 (stop=0) in any state with load_val != 0: count <= load_val; reload <= load_val; mode register <= mode; next state RUN. running rises the cycle after start.
REQ-019 start=1 (stop=0) with load_val == 0: count <= 0; next state EXPIRED; expire pulses and timeout sets on the cycle after start, in both modes. This prevents a zero-period loop.
REQ-020 In RUN with tick_en=1 and count > 1: count decrements by exactly 1.
REQ-021 In RUN with tick_en=1 and count == 1: count <= 0; expire=1 for exactly the following cycle; timeout <= 1.
REQ-022 On the REQ-021 edge, one-shot mode: next state EXPIRED; periodic mode: count <= reload instead of 0 and the channel stays in RUN.
REQ-023 Expiry in periodic mode SHALL occur exactly every reload tick_en strobes, with no lost or extra ticks across the wrap.
REQ-024 In RUN with tick_en=0: count holds.
REQ-025 Changes to load_val or mode while the channel is running SHALL have no effect until the next start.
REQ-026 Start while in RUN SHALL restart the channel from the new load_val; no expire pulse is generated for the abandoned period, even when count == 1 and tick_en=1 in that same cycle.
REQ-027 IDLE and EXPIRED SHALL ignore tick_en; count holds.
REQ-028 clear=1 SHALL reset timeout to 0 on the next edge. If an expiry occurs in the same cycle, set wins and timeout = 1.
REQ-029 timeout SHALL remain set through start, stop and periodic reloads until cleared or reset.
REQ-030 Channels SHALL NOT interact: simultaneous events on different channels are handled independently within the same cycle.
REQ-031 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-032 reset=1 SHALL override all other inputs and, on the next edge, force every channel to IDLE with count, reload, mode, running, expire and timeout all 0.
REQ-033 Reset asserted mid-count SHALL abort the channel without an expire pulse; after reset deasserts, the channel stays IDLE until a new start.

Verification
REQ-034 N_CH=4, WIDTH=16; ch0 start with load_val=3, mode=0, tick_en=1 continuously -> running=1 for 3 cycles; expire pulses once; timeout=1; state EXPIRED; count_o=0; running=0.
REQ-035 ch1 start with load_val=2, mode=1, tick_en high every 2nd cycle -> expire pulses every 4 cycles, count_o sequence 2,1,2,1,...; load_val changed to 9 mid-run has no effect.
REQ-036 ch2 running at count 5; stop and start both asserted in the same cycle -> IDLE; count_o=5; no expire. Then start alone with load_val=0 -> expire pulse the following cycle; timeout=1; state EXPIRED.
REQ-037 ch3 periodic at count 1 with tick_en=1 and clear=1 in the same cycle -> expire=1; timeout=1; count_o reloads. Clear alone next cycle -> timeout=0 while running stays 1.
REQ-038 All four channels started with different values; reset asserted mid-count -> all outputs 0 after one edge; no expire; channels stay IDLE with tick_en=1 until restarted.
